// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// lc3b_types : shared widths, word/mask types and fetch FSM state encoding.
// Revision   : 1.0
// ============================================================================
package lc3b_types;

    localparam int LC3B_ADDR_WIDTH = 16;
    localparam int LC3B_DATA_WIDTH = 16;

    typedef logic [LC3B_DATA_WIDTH-1:0]   lc3b_word;
    typedef logic [LC3B_DATA_WIDTH/8-1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : power-of-two prefetch FIFO with flush; head is the oldest entry.
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction fetch FSM feeding a prefetch queue, with redirect.
//              Optional memory watchdog enabled by macro FETCH_TIMEOUT_EN.
// Revision   : 1.0
// ============================================================================
module fetch_ctrl
    import lc3b_types::*;
#(
    parameter int                    ADDR_WIDTH = LC3B_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = LC3B_DATA_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic                    mem_resp,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    inst_valid,
    output logic [DATA_WIDTH-1:0]   inst,
    output logic [ADDR_WIDTH-1:0]   inst_pc,
    input  logic                    inst_ready,
    output logic                    mem_timeout
);

    localparam int            BYTES    = DATA_WIDTH / 8;
    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam int            QW       = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

    fetch_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_read_q, mem_read_d;

    logic                    q_push;
    logic                    q_pop;
    logic                    q_flush;
    logic [CW-1:0]           q_count;
    logic [QW-1:0]           q_head;

    assign inst_valid = (q_count != '0);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q_push     = 1'b0;
        q_flush    = redirect;
        q_pop      = inst_valid && inst_ready && !redirect;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (q_count < DEPTH_C) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = mem_resp ? S_REQ : S_DRAIN;
                end else if (mem_resp) begin
                    q_push     = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(BYTES);
                    state_d    = (q_count == DEPTH_M1 && !q_pop) ? S_IDLE : S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (mem_resp) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        mem_read_d = (state_d != S_IDLE);
        // DRAIN keeps presenting the abandoned address until its response lands.
        mem_addr_d = (state_d == S_REQ) ? fetch_pc_d : mem_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_read_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_read_q <= mem_read_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data ({mem_rdata, mem_addr_q}),
        .pop       (q_pop),
        .flush     (q_flush),
        .count     (q_count),
        .head      (q_head)
    );

    assign mem_address = mem_addr_q;
    assign mem_read    = mem_read_q;
    assign inst_pc     = q_head[ADDR_WIDTH-1:0];

    generate
        if (DATA_WIDTH == LC3B_DATA_WIDTH) begin : g_lc3b_word
            lc3b_word      inst_w;
            lc3b_mem_wmask wmask_w;
            assign inst_w          = q_head[QW-1:ADDR_WIDTH];
            assign wmask_w         = mem_read_q ? '1 : '0;
            assign inst            = inst_w;
            assign mem_byte_enable = wmask_w;
        end else begin : g_generic_word
            assign inst            = q_head[QW-1:ADDR_WIDTH];
            assign mem_byte_enable = mem_read_q ? '1 : '0;
        end
    endgenerate

`ifdef FETCH_TIMEOUT_EN
    localparam int            WW  = clog2_min1(TIMEOUT + 1);
    localparam logic [WW-1:0] TMO = WW'(TIMEOUT);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        wdog_d = wdog_q;
        if (mem_resp) begin
            wdog_d = '0;
        end else if (mem_read_q && wdog_q != TMO) begin
            wdog_d = wdog_q + WW'(1);
        end
        timeout_d = timeout_q | (wdog_d == TMO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;
`else
    assign mem_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_ctrl : directed bench with a queue-level reference model for fetch_ctrl.
// Revision      : 1.0
// ============================================================================
module tb_fetch_ctrl;

    localparam int          AW    = 16;
    localparam int          DW    = 16;
    localparam int          DEPTH = 4;
    localparam int          TMO   = 8;
    localparam logic [15:0] RPC   = 16'h0000;
`ifdef FETCH_TIMEOUT_EN
    localparam bit          TO_EN = 1'b1;
`else
    localparam bit          TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        mem_timeout;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RPC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .mem_timeout     (mem_timeout)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding request, discard flag, fetch address, queue.
    logic [31:0] mq[$];
    logic [15:0] m_pc, m_addr;
    bit          m_busy, m_disc, m_to, m_ok = 1'b0;
    int          m_cnt;
    logic [15:0] acc_log[$];
    logic [31:0] pop_log[$];

    always @(posedge clk) begin
        bit pop;
        int sz;
        if (!rst_n) begin
            mq.delete();
            m_pc = RPC; m_addr = RPC; m_busy = 1'b1; m_disc = 1'b0;
            m_cnt = 0; m_to = 1'b0; m_ok = 1'b1;
        end else if (m_ok) begin
            sz  = mq.size();
            pop = (sz > 0) && inst_ready && !redirect;
            if (mem_resp) m_cnt = 0;
            else if (m_busy) m_cnt++;
            if (m_cnt >= TMO) m_to = 1'b1;
            if (pop) void'(mq.pop_front());
            if (redirect) begin
                mq.delete();
                m_pc = redirect_pc;
                if (m_busy && !mem_resp) m_disc = 1'b1;
                else begin m_busy = 1'b1; m_disc = 1'b0; m_addr = redirect_pc; end
            end else if (!m_busy) begin
                if (sz < DEPTH) begin m_busy = 1'b1; m_addr = m_pc; end
            end else if (mem_resp) begin
                if (m_disc) begin
                    m_disc = 1'b0; m_addr = m_pc;
                end else begin
                    mq.push_back({mem_rdata, m_addr});
                    m_pc = m_pc + 16'd2;
                    if (mq.size() < DEPTH) m_addr = m_pc;
                    else m_busy = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_read && mem_resp) acc_log.push_back(mem_address);
        if (rst_n && inst_valid && inst_ready && !redirect) pop_log.push_back({inst, inst_pc});
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("mem_read", {31'd0, mem_read}, {31'd0, m_busy});
            if (m_busy) begin
                check("mem_address", {16'd0, mem_address}, {16'd0, m_addr});
                check("byte_enable", {30'd0, mem_byte_enable}, 32'h3);
            end
            check("inst_valid", {31'd0, inst_valid}, {31'd0, (mq.size() > 0)});
            if (mq.size() > 0) check("inst/inst_pc", {inst, inst_pc}, mq[0]);
            check("mem_timeout", {31'd0, mem_timeout}, {31'd0, TO_EN & m_to});
        end
    end

    // Memory responder: answers each read after `waits` idle cycles with 0x1000+addr.
    int mode  = 0;
    int waits = 0;
    int wcnt  = 0;

    task automatic tick();
        @(negedge clk);
        #1;
        redirect = 1'b0;
        if (mode == 1 && rst_n && mem_read) begin
            if (wcnt >= waits) begin
                mem_resp  = 1'b1;
                mem_rdata = 16'h1000 + mem_address;
                wcnt      = 0;
            end else begin
                mem_resp = 1'b0;
                wcnt++;
            end
        end else begin
            mem_resp = 1'b0;
        end
    endtask

    task automatic do_reset(input int md, input int w, input logic rdy);
        rst_n = 1'b0; mode = md; waits = w; inst_ready = rdy;
        repeat (3) tick();
        wcnt  = 0;
        rst_n = 1'b1;
        check("rst mem_read", {31'd0, mem_read}, 32'd1);
        check("rst mem_address", {16'd0, mem_address}, {16'd0, RPC});
        check("rst inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst mem_timeout", {31'd0, mem_timeout}, 32'd0);
    endtask

    initial begin
        int ba, bp, n, idx;
        bit hit;

        // Two-wait memory, consumer always ready.
        ba = acc_log.size(); bp = pop_log.size();
        do_reset(1, 2, 1'b1);
        repeat (14) tick();
        check("seq reads", 32'(acc_log.size() - ba >= 3), 32'd1);
        if (acc_log.size() - ba >= 3) begin
            check("read0 addr", {16'd0, acc_log[ba]},   32'h0000);
            check("read1 addr", {16'd0, acc_log[ba+1]}, 32'h0002);
            check("read2 addr", {16'd0, acc_log[ba+2]}, 32'h0004);
        end
        check("seq pops", 32'(pop_log.size() - bp >= 2), 32'd1);
        if (pop_log.size() - bp >= 2) begin
            check("pop0", pop_log[bp],   32'h1000_0000);
            check("pop1", pop_log[bp+1], 32'h1002_0002);
        end

        // Zero-wait memory, stalled consumer: fill to DEPTH then one pop.
        do_reset(1, 0, 1'b0);
        ba = acc_log.size(); bp = pop_log.size();
        repeat (10) tick();
        check("fill reads", 32'(acc_log.size() - ba), 32'd4);
        check("fill idle", {31'd0, mem_read}, 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        repeat (8) tick();
        check("refill reads", 32'(acc_log.size() - ba), 32'd5);
        check("refill idle", {31'd0, mem_read}, 32'd0);
        check("single pop", 32'(pop_log.size() - bp), 32'd1);
        if (pop_log.size() > bp) check("single pop val", pop_log[bp], 32'h1000_0000);

        // Redirect while the read of 0x0004 is still waiting.
        do_reset(1, 2, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            if (mem_read && mem_address == 16'h0004 && !mem_resp) hit = 1'b1;
        end
        check("reach 0x0004", {31'd0, hit}, 32'd1);
        redirect = 1'b1; redirect_pc = 16'h3000;
        ba = acc_log.size(); bp = pop_log.size();
        tick();
        check("drain flush", {31'd0, inst_valid}, 32'd0);
        check("drain read", {31'd0, mem_read}, 32'd1);
        check("drain addr", {16'd0, mem_address}, 32'h0004);
        inst_ready = 1'b1;
        repeat (12) tick();
        check("drain reads", 32'(acc_log.size() - ba >= 2), 32'd1);
        if (acc_log.size() - ba >= 2) begin
            check("drained addr", {16'd0, acc_log[ba]},   32'h0004);
            check("post-drain addr", {16'd0, acc_log[ba+1]}, 32'h3000);
        end
        n = 0;
        for (int i = bp; i < pop_log.size(); i++) if (pop_log[i][15:0] == 16'h0004) n++;
        check("drained dropped", 32'(n), 32'd0);
        if (pop_log.size() > bp) check("redirect pop", pop_log[bp], 32'h4000_3000);
        else check("redirect pop present", 32'd0, 32'd1);

        // Redirect coincident with a response, then address wrap.
        do_reset(1, 1, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            if (mem_resp && mem_address == 16'h0002) hit = 1'b1;
        end
        check("reach resp 0x0002", {31'd0, hit}, 32'd1);
        redirect = 1'b1; redirect_pc = 16'h2000;
        bp = pop_log.size();
        tick();
        check("coincident addr", {16'd0, mem_address}, 32'h2000);
        check("coincident read", {31'd0, mem_read}, 32'd1);
        repeat (8) tick();
        n = 0;
        for (int i = bp; i < pop_log.size(); i++) if (pop_log[i][15:0] == 16'h0002) n++;
        check("coincident dropped", 32'(n), 32'd0);
        if (pop_log.size() > bp) check("coincident pop", pop_log[bp], 32'h3000_2000);
        else check("coincident pop present", 32'd0, 32'd1);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        ba = acc_log.size();
        repeat (12) tick();
        idx = -1;
        for (int i = ba; i < acc_log.size(); i++) if (idx < 0 && acc_log[i] == 16'hFFFE) idx = i;
        check("wrap found", 32'(idx >= 0 && idx + 1 < acc_log.size()), 32'd1);
        if (idx >= 0 && idx + 1 < acc_log.size()) check("wrap addr", {16'd0, acc_log[idx+1]}, 32'h0000);

        // Silent memory exercises the watchdog.
        do_reset(0, 0, 1'b0);
        repeat (7) tick();
        check("wdog 7", {31'd0, mem_timeout}, 32'd0);
        tick();
        check("wdog 8", {31'd0, mem_timeout}, {31'd0, TO_EN});
        mode = 1;
        repeat (4) tick();
        check("wdog sticky", {31'd0, mem_timeout}, {31'd0, TO_EN});

        // Reset mid-request with three queued entries.
        do_reset(1, 1, 1'b0);
        ba = acc_log.size();
        for (int i = 0; i < 50 && (acc_log.size() - ba) < 3; i++) tick();
        check("three queued", 32'(acc_log.size() - ba), 32'd3);
        rst_n = 1'b0;
        tick();
        wcnt  = 0;
        rst_n = 1'b1;
        check("mid rst valid", {31'd0, inst_valid}, 32'd0);
        check("mid rst addr", {16'd0, mem_address}, {16'd0, RPC});
        check("mid rst read", {31'd0, mem_read}, 32'd1);
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
